// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: sweep FSM encoding and address-width helper.
package regfile_sb_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } sweep_state_t;

    // Bits needed to address n entries (n is a power of two).
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write flags; flush beats a new claim, and a new claim beats a completing write.
module regfile_sb_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            sysclk_i,
    input  logic            sysreset_i,
    input  logic            flush_i,
    input  logic            claim_en_i,
    input  logic [AW-1:0]   claim_addr_i,
    input  logic            clr_en_i,
    input  logic [AW-1:0]   clr_addr_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (clr_en_i)   busy_d[clr_addr_i]   = 1'b0;
            if (claim_en_i) busy_d[claim_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge sysclk_i) begin
        if (sysreset_i) busy_q <= '0;
        else            busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with zero-latency reads, optional write-to-read bypass and a pending-write scoreboard.
// Register 0 is hardwired to zero; after reset a sweep clears the array before traffic is accepted.
//
// state | meaning
// SWEEP | clearing array[cnt], cnt = 1..NREG-1; writes/claims ignored, reads and busy return 0
// READY | normal operation, init_done = 1
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NREG   = 32,
    parameter int  NRP    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = calc_aw(NREG)
) (
    input  logic                sysclk,
    input  logic                sysreset,
    output logic                init_done,
    input  logic                we,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_data,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                claim_en,
    input  logic [AW-1:0]       claim_addr,
    input  logic                flush
);

    sweep_state_t    state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            sweep_clr;
    logic            ready;
    logic            wr_en;
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] mem_q [1:NREG-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sweep_clr = 1'b0;
        case (state_q)
            SWEEP: begin
                sweep_clr = 1'b1;
                if (cnt_q == AW'(NREG - 1)) state_d = READY;
                else                        cnt_d   = cnt_q + AW'(1);
            end
            READY:   ;
            default: state_d = SWEEP;
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_done = ready;
    assign wr_en     = we && ready && (rd_addr != '0);

    // Array has no reset of its own: the sweep is what clears it.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q <= SWEEP;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sweep_clr)  mem_q[cnt_q]   <= '0;
            else if (wr_en) mem_q[rd_addr] <= rd_data;
        end
    end

    regfile_sb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .sysclk_i     (sysclk),
        .sysreset_i   (sysreset),
        .flush_i      (flush),
        .claim_en_i   (claim_en && ready),
        .claim_addr_i (claim_addr),
        .clr_en_i     (we && ready),
        .clr_addr_i   (rd_addr),
        .busy_o       (busy)
    );

    for (genvar k = 0; k < NRP; k++) begin : g_rp
        logic [AW-1:0] addr;
        logic          fwd;

        assign addr = rs_addr[k*AW +: AW];
        assign fwd  = (BYPASS != 0) && wr_en && (rd_addr == addr);

        assign rs_data[k*XLEN +: XLEN] = (!ready || addr == '0) ? '0 :
                                         fwd                    ? rd_data :
                                                                  mem_q[addr];
        // A forwarded write resolves the pending flag in the same cycle.
        assign rs_busy[k] = ready && !fwd && busy[addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep timing, bypass vs no-bypass, register 0, scoreboard and flush.
module tb_regfile_sb;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  rs_addr;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;

    logic        init_done, init_done_nb;
    logic [63:0] rs_data, rs_data_nb;
    logic [1:0]  rs_busy, rs_busy_nb;

    int n_chk  = 0;
    int n_fail = 0;
    int n_edge;

    always #5 sysclk = ~sysclk;

    regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) u_dut (
        .sysclk(sysclk), .sysreset(sysreset), .init_done(init_done),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) u_nb (
        .sysclk(sysclk), .sysreset(sysreset), .init_done(init_done_nb),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
        .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
        settle();
    endtask

    // Count edges from now until init_done rises, bounded.
    task automatic count_to_ready(output int n);
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        sysreset = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
        rs_addr = '0; claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
        tick();
        sysreset = 1'b0;

        // Sweep: traffic is dropped, reads and busy forced low.
        we = 1'b1; rd_addr = 5'd6; rd_data = 32'h0000_AAAA;
        claim_en = 1'b1; claim_addr = 5'd6;
        set_rs(5'd6, 5'd6);
        check_eq("init_done_after_reset", init_done, 0);
        check_eq("sweep_rs_data0", rs_data[31:0], 0);
        check_eq("sweep_rs_busy", rs_busy, 0);
        count_to_ready(n_edge);
        we = 1'b0; claim_en = 1'b0;
        check_eq("sweep_edges", n_edge, 31);
        set_rs(5'd6, 5'd6);
        check_eq("sweep_write_dropped", rs_data[31:0], 0);
        check_eq("sweep_claim_dropped", rs_busy, 0);
        for (int a = 0; a < 32; a++) begin
            set_rs(5'(a), 5'(31 - a));
            check_eq($sformatf("clear_p0_r%0d", a), rs_data[31:0], 0);
            check_eq($sformatf("clear_p1_r%0d", 31 - a), rs_data[63:32], 0);
        end

        // Bypass vs no bypass.
        rs_addr = {5'd0, 5'd5};
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        settle();
        check_eq("bypass_same_cycle", rs_data[31:0], 32'hDEAD_BEEF);
        check_eq("nobypass_same_cycle", rs_data_nb[31:0], 0);
        tick();
        we = 1'b0;
        settle();
        check_eq("bypass_next_cycle", rs_data[31:0], 32'hDEAD_BEEF);
        check_eq("nobypass_next_cycle", rs_data_nb[31:0], 32'hDEAD_BEEF);

        // Register 0 is hardwired.
        rs_addr = {5'd0, 5'd5};
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h0000_1234;
        settle();
        check_eq("r0_write_same_cycle", rs_data[63:32], 0);
        tick();
        we = 1'b0;
        settle();
        check_eq("r0_write_next_cycle", rs_data[63:32], 0);
        claim_en = 1'b1; claim_addr = 5'd0;
        tick();
        claim_en = 1'b0;
        settle();
        check_eq("r0_claim_busy", rs_busy[1], 0);

        // Claim 7, write two cycles later.
        rs_addr = {5'd0, 5'd7};
        claim_en = 1'b1; claim_addr = 5'd7;
        tick();
        claim_en = 1'b0;
        settle();
        check_eq("claim7_cycle1", rs_busy[0], 1);
        tick();
        check_eq("claim7_cycle2", rs_busy[0], 1);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_0077;
        settle();
        check_eq("claim7_fwd_busy", rs_busy[0], 0);
        check_eq("claim7_nofwd_busy", rs_busy_nb[0], 1);
        tick();
        we = 1'b0;
        settle();
        check_eq("claim7_cleared", rs_busy[0], 0);
        check_eq("claim7_cleared_nb", rs_busy_nb[0], 0);
        check_eq("claim7_data", rs_data[31:0], 32'h0000_0077);

        // Claim and write to 7 together: claim wins.
        claim_en = 1'b1; claim_addr = 5'd7;
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_0088;
        tick();
        claim_en = 1'b0; we = 1'b0;
        settle();
        check_eq("claim_write_same_busy", rs_busy[0], 1);
        check_eq("claim_write_same_busy_nb", rs_busy_nb[0], 1);
        check_eq("claim_write_same_data", rs_data[31:0], 32'h0000_0088);

        // Claims then flush with a simultaneous claim.
        claim_en = 1'b1;
        claim_addr = 5'd3;  tick();
        claim_addr = 5'd9;  tick();
        claim_addr = 5'd31; tick();
        claim_en = 1'b0;
        set_rs(5'd3, 5'd9);
        check_eq("claimed_3_9", rs_busy, 2'b11);
        set_rs(5'd31, 5'd4);
        check_eq("claimed_31_not4", rs_busy, 2'b01);
        flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd4;
        tick();
        flush = 1'b0; claim_en = 1'b0;
        set_rs(5'd3, 5'd9);
        check_eq("flush_3_9", rs_busy, 0);
        set_rs(5'd31, 5'd4);
        check_eq("flush_31_4", rs_busy, 0);
        set_rs(5'd7, 5'd7);
        check_eq("flush_7", rs_busy, 0);
        set_rs(5'd5, 5'd7);
        check_eq("flush_data_r5", rs_data[31:0], 32'hDEAD_BEEF);
        check_eq("flush_data_r7", rs_data[63:32], 32'h0000_0088);

        // Reset in mid-sweep restarts it.
        we = 1'b1; rd_addr = 5'd10; rd_data = 32'h0000_CAFE;
        tick();
        we = 1'b0;
        set_rs(5'd10, 5'd5);
        check_eq("pre_reset_r10", rs_data[31:0], 32'h0000_CAFE);
        sysreset = 1'b1;
        tick();
        sysreset = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        sysreset = 1'b1;
        we = 1'b1; rd_addr = 5'd12; rd_data = 32'h0000_0BAD;
        tick();
        sysreset = 1'b0; we = 1'b0;
        settle();
        check_eq("restart_init_done", init_done, 0);
        count_to_ready(n_edge);
        check_eq("restart_edges", n_edge, 31);
        set_rs(5'd10, 5'd5);
        check_eq("restart_r10", rs_data[31:0], 0);
        check_eq("restart_r5", rs_data[63:32], 0);
        set_rs(5'd12, 5'd12);
        check_eq("restart_r12", rs_data[31:0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-005 SHALL have port sysclk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port sysreset, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port init_done, output, 1, high once the register-clear sweep is complete.
REQ-008 SHALL have port we, input, 1, write enable.
REQ-009 SHALL have port rd_addr, input, AW, write address.
REQ-010 SHALL have port rd_data, input, XLEN, write data.
REQ-011 SHALL have port rs_addr, input, NRP*AW, packed read addresses; port k is at [k*AW +: AW].
REQ-012 SHALL have port rs_data, output, NRP*XLEN, packed read data; port k is at [k*XLEN +: XLEN].
REQ-013 SHALL have port rs_busy, output, NRP, per-read-port pending-write flag.
REQ-014 SHALL have port claim_en, input, 1, issue stage marks the destination register as pending.
REQ-015 SHALL have port claim_addr, input, AW, register being claimed.
REQ-016 SHALL have port flush, input, 1, clears all pending flags (pipeline flush).

Function
REQ-017 SHALL give reads zero latency: rs_data[k] is a combinational function of rs_addr[k] and the array.
REQ-018 SHALL return 0 on a read of register 0 and SHALL discard writes to register 0; register 0 is not stored.
REQ-019 SHALL forward rd_data to rs_data[k] when BYPASS=1, we=1, init_done=1, rd_addr==rs_addr[k] and rd_addr!=0; with BYPASS=0, a read returns the old value until the next edge.
REQ-020 SHALL write rd_data into the array at the edge when we=1, init_done=1 and rd_addr!=0.
REQ-021 SHALL keep one busy bit per register; rs_busy[k] = busy[rs_addr[k]], and SHALL read 0 for register 0 or when a same-cycle write to that address is being forwarded.
REQ-022 SHALL update busy[a] at the edge with this priority, highest first: flush -> 0; claim_en and claim_addr==a -> 1; we and rd_addr==a -> 0; otherwise hold.
REQ-023 SHALL leave busy[a] set after the edge when a claim and a write to the same address occur in the same cycle (the new claim wins).
REQ-024 SHALL never set busy[0].
REQ-025 SHALL leave the data array unchanged on flush; only busy bits are cleared.
REQ-026 SHALL implement a two-state FSM: SWEEP (a counter clears array[cnt] to 0 on each cycle, cnt 1..NREG-1) and READY; it SHALL move SWEEP->READY on the edge after cnt==NREG-1 and then set init_done=1.
REQ-027 SHALL, while in SWEEP, ignore we and claim_en, drive rs_data to 0 and drive rs_busy to 0.

Reset
REQ-028 SHALL, on any edge with sysreset=1, enter SWEEP with cnt=1, clear all busy bits and set init_done=0, including when a sweep or write is in progress.
REQ-029 SHALL reach init_done=1 exactly NREG-1 edges after the last edge with sysreset=1.
REQ-030 SHALL ignore all other inputs while sysreset=1.

Structure
REQ-031 SHALL place the FSM state encoding and the AW derivation function in the shared core package.
REQ-032 SHALL use one sub-module, regfile_sb_scoreboard, holding the busy bits and the REQ-022 priority logic; the sweep FSM, array and bypass logic remain in the top module.

Verification
REQ-033 SHALL cover: pulse sysreset 1 cycle, NREG=32 -> init_done rises 31 edges later; every register reads 0; writes during the sweep are dropped.
REQ-034 SHALL cover: we=1, rd_addr=5, rd_data=0xDEADBEEF, rs_addr[0]=5, BYPASS=1 -> rs_data[0]=0xDEADBEEF in the same cycle; BYPASS=0 -> old value that cycle, new value next cycle.
REQ-035 SHALL cover: write 0x1234 to register 0, then read port 1 at register 0 -> 0; claim of register 0 -> rs_busy stays 0.
REQ-036 SHALL cover: claim 7, then write 7 two cycles later -> rs_busy=1 for 2 cycles, then 0; claim and write 7 in the same cycle -> busy stays 1.
REQ-037 SHALL cover: claim registers 3, 9 and 31, then flush together with a claim of 4 -> all busy bits 0 and array data intact.
REQ-038 SHALL cover: sysreset asserted at sweep count 15 -> sweep restarts and init_done rises 31 edges after sysreset deasserts; registers written before the reset read 0.
